// File: rtl/multicycle_control_if.sv
// rtl/multicycle_control_if.sv - datapath-side signal bundle of the multicycle main control FSM
//
// Purpose: groups the instruction/status inputs and the control strobes that
// pass between the main control FSM and the datapath.
// Ports (as seen by the master = control FSM):
//   in : opcode[3:0], zero, mem_ready
//   out: alu_op[2:0], alu_src, reg_dst, mem_to_reg, reg_write, mem_read,
//        mem_write, ir_write, pc_write, pc_src[1:0], illegal, retire,
//        retired_count[15:0]
interface multicycle_control_if;
  logic [3:0]  opcode;
  logic        zero;
  logic        mem_ready;
  logic [2:0]  alu_op;
  logic        alu_src;
  logic        reg_dst;
  logic        mem_to_reg;
  logic        reg_write;
  logic        mem_read;
  logic        mem_write;
  logic        ir_write;
  logic        pc_write;
  logic [1:0]  pc_src;
  logic        illegal;
  logic        retire;
  logic [15:0] retired_count;

  modport master (
    input  opcode, zero, mem_ready,
    output alu_op, alu_src, reg_dst, mem_to_reg, reg_write, mem_read,
           mem_write, ir_write, pc_write, pc_src, illegal, retire,
           retired_count
  );

  modport slave (
    output opcode, zero, mem_ready,
    input  alu_op, alu_src, reg_dst, mem_to_reg, reg_write, mem_read,
           mem_write, ir_write, pc_write, pc_src, illegal, retire,
           retired_count
  );
endinterface

// File: rtl/multicycle_control.sv
// rtl/multicycle_control.sv - multicycle main control FSM for the 16-bit RISC core
//
// Purpose: sequences each instruction through FETCH, DECODE, EXEC, MEM and WB,
// drives the ALU operation code and datapath strobes, traps undefined opcodes
// and counts retired instructions.
// Ports:
//   clk   : system clock, rising edge
//   rst_n : asynchronous active-low reset
//   bus   : multicycle_control_if.master (opcode/zero/mem_ready in, strobes out)
module multicycle_control (
  input  logic                        clk,
  input  logic                        rst_n,
  multicycle_control_if.master        bus
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd5
  } state_t;

  state_t      state;
  state_t      state_nxt;
  logic [3:0]  op_q;
  logic [15:0] count_q;

  logic       is_ld, is_st, is_r, is_beq, is_bne, is_jmp;
  logic [2:0] r_op;
  logic [2:0] exec_alu_op;
  logic       op_illegal;

  // Class decode of the latched opcode (used from EXEC onwards).
  assign is_ld  = (op_q == 4'h0);
  assign is_st  = (op_q == 4'h1);
  assign is_r   = (op_q >= 4'h2) && (op_q <= 4'h9);
  assign is_beq = (op_q == 4'hB);
  assign is_bne = (op_q == 4'hC);
  assign is_jmp = (op_q == 4'hD);

  // R-type ALU code is opcode - 2; modulo-8 arithmetic on the low bits gives
  // the same result for 0010..1001.
  assign r_op = op_q[2:0] - 3'd2;

  assign exec_alu_op = is_r ? r_op :
                       (is_beq || is_bne) ? 3'b001 : 3'b000;

  // DECODE decides on the live IR opcode, which is valid from this cycle on.
  assign op_illegal = (bus.opcode == 4'hA) || (bus.opcode == 4'hE) ||
                      (bus.opcode == 4'hF);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= S_FETCH;
      op_q    <= 4'h0;
      count_q <= 16'h0000;
    end else begin
      state <= state_nxt;
      if (state == S_DECODE) begin
        op_q <= bus.opcode;
      end
      if (bus.retire) begin
        count_q <= count_q + 16'd1;
      end
    end
  end

  assign bus.retired_count = count_q;

  always_comb begin
    state_nxt      = state;
    bus.alu_op     = 3'b000;
    bus.alu_src    = 1'b0;
    bus.reg_dst    = 1'b0;
    bus.mem_to_reg = 1'b0;
    bus.reg_write  = 1'b0;
    bus.mem_read   = 1'b0;
    bus.mem_write  = 1'b0;
    bus.ir_write   = 1'b0;
    bus.pc_write   = 1'b0;
    bus.pc_src     = 2'b00;
    bus.illegal    = 1'b0;
    bus.retire     = 1'b0;

    case (state)
      S_FETCH: begin
        bus.mem_read = 1'b1;
        if (bus.mem_ready) begin
          bus.ir_write = 1'b1;
          bus.pc_write = 1'b1;
          state_nxt    = S_DECODE;
        end
      end
      S_DECODE: begin
        state_nxt = op_illegal ? S_TRAP : S_EXEC;
      end
      S_EXEC: begin
        bus.alu_op = exec_alu_op;
        state_nxt  = S_FETCH;
        if (is_r) begin
          state_nxt = S_WB;
        end else if (is_ld || is_st) begin
          bus.alu_src = 1'b1;
          state_nxt   = S_MEM;
        end else if (is_beq || is_bne) begin
          bus.pc_write = is_beq ? bus.zero : !bus.zero;
          bus.pc_src   = 2'b01;
          bus.retire   = 1'b1;
        end else if (is_jmp) begin
          bus.pc_write = 1'b1;
          bus.pc_src   = 2'b10;
          bus.retire   = 1'b1;
        end
      end
      S_MEM: begin
        bus.alu_op    = exec_alu_op;
        bus.alu_src   = 1'b1;
        bus.mem_read  = is_ld;
        bus.mem_write = is_st;
        if (bus.mem_ready) begin
          if (is_ld) begin
            state_nxt = S_WB;
          end else begin
            bus.retire = 1'b1;
            state_nxt  = S_FETCH;
          end
        end
      end
      S_WB: begin
        bus.reg_write  = 1'b1;
        bus.retire     = 1'b1;
        bus.mem_to_reg = is_ld;
        bus.reg_dst    = is_r;
        state_nxt      = S_FETCH;
      end
      S_TRAP: begin
        bus.illegal = 1'b1;
      end
      default: begin
        state_nxt = S_FETCH;
      end
    endcase

    // Reset forces every output low at once, abandoning any memory request.
    if (!rst_n) begin
      bus.alu_op     = 3'b000;
      bus.alu_src    = 1'b0;
      bus.reg_dst    = 1'b0;
      bus.mem_to_reg = 1'b0;
      bus.reg_write  = 1'b0;
      bus.mem_read   = 1'b0;
      bus.mem_write  = 1'b0;
      bus.ir_write   = 1'b0;
      bus.pc_write   = 1'b0;
      bus.pc_src     = 2'b00;
      bus.illegal    = 1'b0;
      bus.retire     = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// tb/tb_multicycle_control.sv - self-checking bench for multicycle_control
module tb_multicycle_control;

  logic clk;
  logic rst_n;

  multicycle_control_if bus ();

  multicycle_control dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.master)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Output vector layout: {alu_op[2:0], alu_src, reg_dst, mem_to_reg,
  // reg_write, mem_read, mem_write, ir_write, pc_write, pc_src[1:0],
  // illegal, retire}
  localparam logic [14:0] SRC  = 15'h0800;
  localparam logic [14:0] RDST = 15'h0400;
  localparam logic [14:0] M2R  = 15'h0200;
  localparam logic [14:0] RW   = 15'h0100;
  localparam logic [14:0] MR   = 15'h0080;
  localparam logic [14:0] MW   = 15'h0040;
  localparam logic [14:0] IRW  = 15'h0020;
  localparam logic [14:0] PCW  = 15'h0010;
  localparam logic [14:0] PCBR = 15'h0004;
  localparam logic [14:0] PCJ  = 15'h0008;
  localparam logic [14:0] ILL  = 15'h0002;
  localparam logic [14:0] RET  = 15'h0001;
  localparam logic [14:0] FOK  = MR | IRW | PCW;

  function automatic logic [14:0] alu(input int v);
    logic [14:0] r;
    r = 15'(v) << 12;
    return r;
  endfunction

  typedef struct {
    string       name;
    logic [3:0]  op;
    logic        z;
    logic        rdy;
    logic [14:0] exp;
  } vec_t;

  typedef struct {
    string       name;
    logic [14:0] outs;
    logic [15:0] cnt;
  } sb_t;

  vec_t tbl[$];
  sb_t  sb[$];
  int   checks = 0;
  int   errors = 0;
  logic [15:0] exp_count = 16'h0000;

  function automatic logic [14:0] outs_now();
    return {bus.alu_op, bus.alu_src, bus.reg_dst, bus.mem_to_reg,
            bus.reg_write, bus.mem_read, bus.mem_write, bus.ir_write,
            bus.pc_write, bus.pc_src, bus.illegal, bus.retire};
  endfunction

  task automatic add(input string name, input logic [3:0] op, input logic z,
                     input logic rdy, input logic [14:0] exp);
    vec_t v;
    v.name = name; v.op = op; v.z = z; v.rdy = rdy; v.exp = exp;
    tbl.push_back(v);
  endtask

  task automatic compare_pop();
    sb_t e;
    logic [14:0] got;
    e = sb.pop_front();
    got = outs_now();
    checks++;
    if (got !== e.outs || bus.retired_count !== e.cnt) begin
      errors++;
      $display("FAIL %s: got outs=%h count=%h, expected outs=%h count=%h",
               e.name, got, bus.retired_count, e.outs, e.cnt);
    end
  endtask

  // One clock cycle: drive inputs just after the edge, record the expectation,
  // compare on the falling edge.
  task automatic step(input string name, input logic [3:0] op, input logic z,
                      input logic rdy, input logic [14:0] exp);
    sb_t e;
    bus.opcode    = op;
    bus.zero      = z;
    bus.mem_ready = rdy;
    e.name = name; e.outs = exp; e.cnt = exp_count;
    sb.push_back(e);
    @(negedge clk);
    compare_pop();
    if (exp[0]) exp_count = exp_count + 16'd1;
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset check between clock edges.
  task automatic check_reset_now(input string name);
    sb_t e;
    exp_count = 16'h0000;
    e.name = name; e.outs = 15'h0000; e.cnt = exp_count;
    sb.push_back(e);
    compare_pop();
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: got timeout, expected completion");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n         = 1'b0;
    bus.opcode    = 4'h2;
    bus.zero      = 1'b1;
    bus.mem_ready = 1'b1;

    // ADD
    add("add_fetch", 4'h2, 0, 1, FOK);
    add("add_dec",   4'h2, 0, 1, 15'h0);
    add("add_exec",  4'h2, 0, 1, alu(0));
    add("add_wb",    4'h2, 0, 1, RW | RDST | RET);
    // LD with three wait cycles in MEM
    add("ld_fetch",  4'h0, 0, 1, FOK);
    add("ld_dec",    4'h0, 0, 1, 15'h0);
    add("ld_exec",   4'h0, 0, 1, SRC);
    add("ld_mem_w1", 4'h0, 0, 0, SRC | MR);
    add("ld_mem_w2", 4'h0, 0, 0, SRC | MR);
    add("ld_mem_w3", 4'h0, 0, 0, SRC | MR);
    add("ld_mem",    4'h0, 0, 1, SRC | MR);
    add("ld_wb",     4'h0, 0, 1, RW | M2R | RET);
    // ST with one fetch wait
    add("st_fetch_w", 4'h1, 0, 0, MR);
    add("st_fetch",   4'h1, 0, 1, FOK);
    add("st_dec",     4'h1, 0, 1, 15'h0);
    add("st_exec",    4'h1, 0, 1, SRC);
    add("st_mem",     4'h1, 0, 1, SRC | MW | RET);
    // Branches
    add("beq1_fetch", 4'hB, 1, 1, FOK);
    add("beq1_dec",   4'hB, 1, 1, 15'h0);
    add("beq1_exec",  4'hB, 1, 1, alu(1) | PCW | PCBR | RET);
    add("bne1_fetch", 4'hC, 1, 1, FOK);
    add("bne1_dec",   4'hC, 1, 1, 15'h0);
    add("bne1_exec",  4'hC, 1, 1, alu(1) | PCBR | RET);
    add("bne0_fetch", 4'hC, 0, 1, FOK);
    add("bne0_dec",   4'hC, 0, 1, 15'h0);
    add("bne0_exec",  4'hC, 0, 1, alu(1) | PCW | PCBR | RET);
    add("beq0_fetch", 4'hB, 0, 1, FOK);
    add("beq0_dec",   4'hB, 0, 1, 15'h0);
    add("beq0_exec",  4'hB, 0, 1, alu(1) | PCBR | RET);
    // R-type ALU sweep
    add("sub_fetch", 4'h3, 0, 1, FOK);
    add("sub_dec",   4'h3, 0, 1, 15'h0);
    add("sub_exec",  4'h3, 0, 1, alu(1));
    add("sub_wb",    4'h3, 0, 1, RW | RDST | RET);
    add("and_fetch", 4'h7, 0, 1, FOK);
    add("and_dec",   4'h7, 0, 1, 15'h0);
    add("and_exec",  4'h7, 0, 1, alu(5));
    add("and_wb",    4'h7, 0, 1, RW | RDST | RET);
    add("slt_fetch", 4'h9, 0, 1, FOK);
    add("slt_dec",   4'h9, 0, 1, 15'h0);
    add("slt_exec",  4'h9, 0, 1, alu(7));
    add("slt_wb",    4'h9, 0, 1, RW | RDST | RET);
    // JMP, mem_ready low outside memory states is ignored
    add("jmp_fetch", 4'hD, 0, 1, FOK);
    add("jmp_dec",   4'hD, 0, 0, 15'h0);
    add("jmp_exec",  4'hD, 0, 0, PCW | PCJ | RET);

    @(negedge clk);
    check_reset_now("reset_hold");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    for (int i = 0; i < tbl.size(); i++) begin
      step(tbl[i].name, tbl[i].op, tbl[i].z, tbl[i].rdy, tbl[i].exp);
    end

    // Illegal opcode traps until reset
    step("trap_fetch", 4'hE, 0, 1, FOK);
    step("trap_dec",   4'hE, 0, 1, 15'h0);
    step("trap_1",     4'hE, 1, 0, ILL);
    step("trap_2",     4'h2, 0, 1, ILL);
    step("trap_3",     4'h0, 1, 1, ILL);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_now("trap_reset");
    @(posedge clk);
    #1;
    rst_n = 1'b1;

    // Reset during a ST wait in MEM
    step("st2_fetch", 4'h1, 0, 1, FOK);
    step("st2_dec",   4'h1, 0, 1, 15'h0);
    step("st2_exec",  4'h1, 0, 1, SRC);
    step("st2_mem_w", 4'h1, 0, 0, SRC | MW);
    #2;
    rst_n = 1'b0;
    #1;
    check_reset_now("st2_abort");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    step("restart_fetch", 4'h1, 0, 0, MR);

    // Counter wrap: preload near the top, then retire two JMPs
    step("wrap_fetch1", 4'hD, 0, 1, FOK);
    force dut.count_q = 16'hFFFE;
    #1;
    release dut.count_q;
    exp_count = 16'hFFFE;
    step("wrap_dec1",   4'hD, 0, 1, 15'h0);
    step("wrap_exec1",  4'hD, 0, 1, PCW | PCJ | RET);
    step("wrap_fetch2", 4'hD, 0, 1, FOK);
    step("wrap_dec2",   4'hD, 0, 1, 15'h0);
    step("wrap_exec2",  4'hD, 0, 1, PCW | PCJ | RET);
    step("wrap_fetch3", 4'hD, 0, 0, MR);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
